spi_cfg_master: RTL
===================

# spi_cfg_master

SPI-slave front end that turns serial frames from the off-chip tester into single-cycle write/read operations on the configuration register file. It drives the register file's write_addr/write_data/write and read_addr/read ports, and returns readback data on miso. All logic runs on clk; SPI pins are asynchronous inputs, synchronized internally.

## Interface
- SYNC_STAGES, 2: synchronizer flops on sclk, cs_n and mosi (legal values 2-3).
- clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous, active-low.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
- cs_n  input  1  SPI chip select, active-low, frames transactions.
- mosi  input  1  SPI serial data in, MSB first.
- miso  output  1  SPI serial data out, MSB first; 0 when not shifting read data.
- write_addr  output  8  register file write address.
- write_data  output  8  register file write data.
- write  output  1  one-clk write strobe.
- read_addr  output  8  register file read address.
- read  output  1  one-clk read strobe.
- read_data  input  8  register file readback; valid 1 clk after read.

## Operation
- Frame: 24 bits while cs_n low. Byte0 = command: bit7=1 write, bit7=0 read; bits 6:0 ignored. Byte1 = address. Byte2 = write data (write), don't-care on mosi (read).
- mosi sampled on detected sclk rising edges; miso updated on detected sclk falling edges.
- FSM states: IDLE, CMD, ADDR, DATA, DONE.
  - IDLE: wait for synchronized cs_n low -> CMD, bit counter cleared.
  - CMD: after 8th rising edge latch command -> ADDR.
  - ADDR: after 16th rising edge latch address. If read: drive read_addr=address, pulse read for one clk, capture read_data into the 8-bit output shift register the following clk. Then -> DATA.
  - DATA: after 24th rising edge, if write: drive write_addr=address and write_data=byte2, pulse write for one clk. Then -> DONE.
  - DONE: further sclk edges ignored; miso=0; wait for cs_n high -> IDLE.
- From any non-IDLE state, cs_n high -> IDLE with no strobe issued. An aborted write frame (<24 bits) never writes; an aborted read that already pulsed read has no further side effect.
- miso during a read frame's DATA state: the falling edge after rising edge 16 presents bit7 of captured data; each following falling edge presents the next lower bit. miso=0 in every other state and during write frames.
- write_addr, write_data, read_addr hold their last values between strobes.
- write and read are never asserted in the same clk, and each is at most one pulse per frame.

## Timing
- Reset: write=0, read=0, write_addr=0, write_data=0, read_addr=0, miso=0, FSM=IDLE, counters and shift registers 0. Reset mid-frame aborts the frame; the next frame after reset release and a fresh cs_n falling edge is decoded normally.
- Pin-to-detect latency: SYNC_STAGES+1 clk from an sclk/cs_n pin edge to internal edge-detect.
- read pulse: 1 clk after the 16th rising edge is detected; read_data captured 1 clk later.
- write pulse: 1 clk after the 24th rising edge is detected.
- Constraint: sclk high and low phases >= 8 clk periods each; cs_n high >= 8 clk between frames; cs_n falls >= 8 clk before first sclk rising edge. Read capture then completes before the 16th falling edge.
- Back-to-back frames: the DONE->IDLE->CMD path requires only that the cs_n high time is met; no other dead time.

## Test plan
- Write frame 0x80,0x05,0xA5 -> exactly one write pulse with write_addr=0x05, write_data=0xA5; read stays 0.
- Read frame 0x00,0x05,0x00 with read_data model returning 0xA5 -> one read pulse with read_addr=0x05; miso bits on rising edges 17-24 = 1,0,1,0,0,1,0,1; no write.
- Abort: cs_n high after 20 bits of write frame 0x80,0x10,0xFF -> no write pulse; following write frame 0xFF,0x10,0x3C -> write 0x3C to 0x10 (cmd bits 6:0 ignored).
- 28-bit write frame 0x80,0x22,0x11 plus 4 extra bits -> single write of 0x11 to 0x22; extra bits ignored; miso stays 0.
- reset_n asserted at bit 12 of a frame -> all outputs 0 immediately; after release, read frame 0x00,0x7F -> read_addr=0x7F, one read pulse.
- Back-to-back write then read of 0x40 at sclk = clk/16, 8-clk cs_n gap -> write 0x5A to 0x40, then miso shifts 0x5A.

Source files
------------

// File: rtl/spi_cfg_master_if.sv
// Register-file side of spi_cfg_master.
//   master modport (the SPI front end): drives the write port
//     (write_addr, write_data, write) and the read port (read_addr, read),
//     and takes read_data back.
//   slave modport (the register file): the mirror image.
// read_data is expected one clk after the read strobe.
interface spi_cfg_master_if;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic       write;
  logic [7:0] read_addr;
  logic       read;
  logic [7:0] read_data;

  modport master (
    output write_addr,
    output write_data,
    output write,
    output read_addr,
    output read,
    input  read_data
  );

  modport slave (
    input  write_addr,
    input  write_data,
    input  write,
    input  read_addr,
    input  read,
    output read_data
  );
endinterface

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: SPI-slave (mode 0) front end that turns 24-bit tester
// frames into single-cycle register file write/read operations.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   sclk     SPI clock, asynchronous to clk
//   cs_n     SPI chip select, active-low
//   mosi     SPI data in, MSB first
//   miso     SPI data out, MSB first, 0 unless shifting read data
//   regs     register file port (spi_cfg_master_if.master)
// Frame: command byte (bit7=1 write, 0 read), address byte, data byte.
module spi_cfg_master #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  spi_cfg_master_if.master regs
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;

  logic       sclk_d_r;
  logic       sclk_rise_r;
  logic       sclk_fall_r;
  logic       cs_d_r;
  logic       cs_fall_r;
  logic       mosi_r;

  logic [2:0] state_r;
  logic [4:0] bit_cnt_r;
  logic [7:0] shift_in_r;
  logic [7:0] shift_out_r;
  logic [7:0] addr_r;
  logic       cmd_wr_r;
  logic       cap_pend_r;
  logic       miso_r;
  logic [7:0] write_addr_r;
  logic [7:0] write_data_r;
  logic       write_r;
  logic [7:0] read_addr_r;
  logic       read_r;

  logic [7:0] byte_s;
  logic       in_frame_s;

  // Byte completed by the bit arriving on the current rising edge.
  assign byte_s     = {shift_in_r[6:0], mosi_r};
  assign in_frame_s = (state_r == ST_CMD) || (state_r == ST_ADDR) || (state_r == ST_DATA);

  assign miso            = miso_r;
  assign regs.write_addr = write_addr_r;
  assign regs.write_data = write_data_r;
  assign regs.write      = write_r;
  assign regs.read_addr  = read_addr_r;
  assign regs.read       = read_r;

  // Metastability synchronizers for the three SPI input pins.
  // cs_n resets to 0 so a chip select that is already low at reset release
  // never looks like a fresh falling edge; a new frame needs cs_n to go high first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_r <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
    end
  end

  // Registered edge detect; mosi_r and cs_d_r are kept aligned with the edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_d_r    <= 1'b0;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      cs_d_r      <= 1'b0;
      cs_fall_r   <= 1'b0;
      mosi_r      <= 1'b0;
    end else begin
      sclk_d_r    <= sclk_sync_r[SYNC_STAGES-1];
      sclk_rise_r <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
      sclk_fall_r <= ~sclk_sync_r[SYNC_STAGES-1] & sclk_d_r;
      cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
      cs_fall_r   <= ~cs_sync_r[SYNC_STAGES-1] & cs_d_r;
      mosi_r      <= mosi_sync_r[SYNC_STAGES-1];
    end
  end

  // Frame decoder FSM, register file strobes and miso shifter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 5'd0;
      shift_in_r   <= 8'd0;
      shift_out_r  <= 8'd0;
      addr_r       <= 8'd0;
      cmd_wr_r     <= 1'b0;
      cap_pend_r   <= 1'b0;
      miso_r       <= 1'b0;
      write_addr_r <= 8'd0;
      write_data_r <= 8'd0;
      write_r      <= 1'b0;
      read_addr_r  <= 8'd0;
      read_r       <= 1'b0;
    end else begin
      write_r    <= 1'b0;
      read_r     <= 1'b0;
      // read_data is valid the clk after the read strobe; sample it then.
      cap_pend_r <= read_r;
      if (cap_pend_r) begin
        shift_out_r <= regs.read_data;
      end

      if (in_frame_s && sclk_rise_r) begin
        shift_in_r <= byte_s;
        bit_cnt_r  <= bit_cnt_r + 5'd1;
      end

      if ((state_r != ST_IDLE) && cs_d_r) begin
        // Chip select released mid-frame or after completion: drop the frame.
        state_r   <= ST_IDLE;
        bit_cnt_r <= 5'd0;
        miso_r    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            miso_r    <= 1'b0;
            bit_cnt_r <= 5'd0;
            if (cs_fall_r) begin
              state_r <= ST_CMD;
            end
          end
          ST_CMD: begin
            miso_r <= 1'b0;
            if (sclk_rise_r && (bit_cnt_r == 5'd7)) begin
              cmd_wr_r <= byte_s[7];
              state_r  <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            miso_r <= 1'b0;
            if (sclk_rise_r && (bit_cnt_r == 5'd15)) begin
              addr_r <= byte_s;
              if (!cmd_wr_r) begin
                read_addr_r <= byte_s;
                read_r      <= 1'b1;
              end
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (sclk_rise_r && (bit_cnt_r == 5'd23)) begin
              if (cmd_wr_r) begin
                write_addr_r <= addr_r;
                write_data_r <= byte_s;
                write_r      <= 1'b1;
              end
              miso_r  <= 1'b0;
              state_r <= ST_DONE;
            end else if (cmd_wr_r) begin
              miso_r <= 1'b0;
            end else if (sclk_fall_r) begin
              miso_r      <= shift_out_r[7];
              shift_out_r <= {shift_out_r[6:0], 1'b0};
            end
          end
          ST_DONE: begin
            miso_r <= 1'b0;
          end
          default: begin
            miso_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
